// File: rtl/lap_edge_stats_pkg.sv
// Shared types and constants for the Laplacian edge-map / frame statistics stage.
package lap_edge_stats_pkg;

  localparam int unsigned LAP_ZERO = 128;
  localparam int unsigned MAG_W    = 8;
  localparam int unsigned CNT_W    = 32;
  localparam int unsigned COORD_W  = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // Per-frame statistics record; coordinates are kept wide and truncated at the outputs.
  typedef struct packed {
    logic [CNT_W-1:0]   count;
    logic [COORD_W-1:0] min_row;
    logic [COORD_W-1:0] max_row;
    logic [COORD_W-1:0] min_col;
    logic [COORD_W-1:0] max_col;
    logic               empty;
  } stats_t;

  // Empty accumulator: count 0, minima all-ones in cw bits, maxima 0.
  function automatic stats_t stats_init(input int unsigned cw);
    stats_t s;
    s = '0;
    if (cw >= COORD_W) begin
      s.min_row = '1;
      s.min_col = '1;
    end else begin
      s.min_row = (COORD_W'(1) << cw) - COORD_W'(1);
      s.min_col = (COORD_W'(1) << cw) - COORD_W'(1);
    end
    s.empty = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/lap_edge_stats_if.sv
// Sample input / edge-map and statistics output bundle of the edge statistics stage.
interface lap_edge_stats_if #(
  parameter int unsigned CW = 16
);
  logic          lap_valid;
  logic [7:0]    lap_out;
  logic [31:0]   center_row_s1;
  logic [31:0]   center_col_s1;
  logic [7:0]    threshold;
  logic          edge_valid;
  logic          edge_bit;
  logic          stats_valid;
  logic [31:0]   edge_count;
  logic [CW-1:0] bbox_min_row;
  logic [CW-1:0] bbox_max_row;
  logic [CW-1:0] bbox_min_col;
  logic [CW-1:0] bbox_max_col;
  logic          bbox_empty;
  logic          range_err;

  modport master (
    output lap_valid, lap_out, center_row_s1, center_col_s1, threshold,
    input  edge_valid, edge_bit, stats_valid, edge_count,
           bbox_min_row, bbox_max_row, bbox_min_col, bbox_max_col,
           bbox_empty, range_err
  );

  modport slave (
    input  lap_valid, lap_out, center_row_s1, center_col_s1, threshold,
    output edge_valid, edge_bit, stats_valid, edge_count,
           bbox_min_row, bbox_max_row, bbox_min_col, bbox_max_col,
           bbox_empty, range_err
  );
endinterface

// File: rtl/lap_edge_stats_mag_thresh.sv
// Combinational |lap - 128| magnitude and strict greater-than threshold compare.
module lap_mag_thresh
  import lap_edge_stats_pkg::*;
(
  input  logic [MAG_W-1:0] i_lap,
  input  logic [MAG_W-1:0] i_thr,
  output logic             o_edge_c
);

  localparam logic [MAG_W-1:0] ZERO = MAG_W'(LAP_ZERO);

  logic [MAG_W-1:0] w_mag;

  // Offset-128 to magnitude; 0 maps to 128, which still fits in MAG_W bits.
  assign w_mag    = (i_lap >= ZERO) ? (i_lap - ZERO) : (ZERO - i_lap);
  assign o_edge_c = (w_mag > i_thr);

endmodule

// File: rtl/lap_edge_stats.sv
// Edge map from Laplacian samples plus per-frame edge count / bounding-box report.
module lap_edge_stats
  import lap_edge_stats_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH  = 320,
  parameter int unsigned IMAGE_HEIGHT = 240,
  parameter int unsigned CW           = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  lap_edge_stats_if.slave bus
);

  localparam logic [31:0] LAST_ROW = 32'(IMAGE_HEIGHT - 1);
  localparam logic [31:0] LAST_COL = 32'(IMAGE_WIDTH - 2);
  localparam stats_t      INIT     = stats_init(CW);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [MAG_W-1:0]   r_thr_q;
  logic [MAG_W-1:0]   w_thr;
  stats_t             r_acc;
  stats_t             w_base;
  stats_t             w_nxt;
  logic               w_in_range;
  logic               w_accept;
  logic               w_frame_end;
  logic               w_edge;
  logic [COORD_W-1:0] w_row;
  logic [COORD_W-1:0] w_col;

  logic               r_edge_valid;
  logic               r_edge_bit;
  logic               r_stats_valid;
  logic [CNT_W-1:0]   r_edge_count;
  logic [CW-1:0]      r_min_row;
  logic [CW-1:0]      r_max_row;
  logic [CW-1:0]      r_min_col;
  logic [CW-1:0]      r_max_col;
  logic               r_bbox_empty;
  logic               r_range_err;

  // Sample qualification and frame-end detection.
  assign w_in_range  = (bus.center_row_s1 < 32'(IMAGE_HEIGHT)) &&
                       (bus.center_col_s1 < 32'(IMAGE_WIDTH));
  assign w_accept    = bus.lap_valid && w_in_range;
  assign w_frame_end = w_accept && (bus.center_row_s1 == LAST_ROW) &&
                       (bus.center_col_s1 == LAST_COL);
  assign w_row       = COORD_W'(CW'(bus.center_row_s1));
  assign w_col       = COORD_W'(CW'(bus.center_col_s1));

  lap_mag_thresh u_mag (
    .i_lap    (bus.lap_out),
    .i_thr    (w_thr),
    .o_edge_c (w_edge)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: any accepted sample opens/continues a frame unless it ends it.
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) w_state_nxt = w_frame_end ? IDLE : ACCUM;
  end

  // State-dependent selects: the first pixel of a frame uses the live threshold and empty stats.
  always_comb begin
    w_thr  = r_thr_q;
    w_base = r_acc;
    if (r_state == IDLE) begin
      w_thr  = bus.threshold;
      w_base = INIT;
    end
  end

  // Statistics including the current sample.
  always_comb begin
    w_nxt = w_base;
    if (w_edge) begin
      w_nxt.count = (w_base.count == '1) ? w_base.count : w_base.count + CNT_W'(1);
      if (w_row < w_base.min_row) w_nxt.min_row = w_row;
      if (w_row > w_base.max_row) w_nxt.max_row = w_row;
      if (w_col < w_base.min_col) w_nxt.min_col = w_col;
      if (w_col > w_base.max_col) w_nxt.max_col = w_col;
    end
    w_nxt.empty = (w_nxt.count == '0);
  end

  // Edge map, accumulators, threshold latch and the frame-end report registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_thr_q       <= '0;
      r_acc         <= INIT;
      r_edge_valid  <= 1'b0;
      r_edge_bit    <= 1'b0;
      r_stats_valid <= 1'b0;
      r_edge_count  <= '0;
      r_min_row     <= '0;
      r_max_row     <= '0;
      r_min_col     <= '0;
      r_max_col     <= '0;
      r_bbox_empty  <= 1'b0;
      r_range_err   <= 1'b0;
    end else begin
      r_edge_valid  <= w_accept;
      r_edge_bit    <= w_accept && w_edge;
      r_stats_valid <= w_frame_end;
      r_range_err   <= r_range_err || (bus.lap_valid && !w_in_range);
      if (w_accept && (r_state == IDLE)) r_thr_q <= bus.threshold;
      if (w_frame_end) begin
        r_acc        <= INIT;
        r_edge_count <= w_nxt.count;
        r_bbox_empty <= w_nxt.empty;
        r_min_row    <= w_nxt.empty ? '0 : CW'(w_nxt.min_row);
        r_max_row    <= w_nxt.empty ? '0 : CW'(w_nxt.max_row);
        r_min_col    <= w_nxt.empty ? '0 : CW'(w_nxt.min_col);
        r_max_col    <= w_nxt.empty ? '0 : CW'(w_nxt.max_col);
      end else if (w_accept) begin
        r_acc <= w_nxt;
      end
    end
  end

  assign bus.edge_valid   = r_edge_valid;
  assign bus.edge_bit     = r_edge_bit;
  assign bus.stats_valid  = r_stats_valid;
  assign bus.edge_count   = r_edge_count;
  assign bus.bbox_min_row = r_min_row;
  assign bus.bbox_max_row = r_max_row;
  assign bus.bbox_min_col = r_min_col;
  assign bus.bbox_max_col = r_max_col;
  assign bus.bbox_empty   = r_bbox_empty;
  assign bus.range_err    = r_range_err;

endmodule

// File: tb/tb_lap_edge_stats.sv
// Self-checking bench: table vectors plus raster sequences, outputs checked via scoreboard queues.
module tb_lap_edge_stats;

  localparam int W  = 320;
  localparam int H  = 240;
  localparam int CW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lap_edge_stats_if #(.CW(CW)) bus ();

  lap_edge_stats #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit e;
    int cyc;
  } exp_edge_t;

  typedef struct {
    logic [31:0] cnt;
    logic [15:0] minr, maxr, minc, maxc;
    bit          empty;
    int          cyc;
  } exp_stats_t;

  typedef struct {
    int lap;
    int thr;
    bit e;
  } vec_t;

  exp_edge_t  q_e[$];
  exp_stats_t q_s[$];
  exp_edge_t  mon_e;
  exp_stats_t mon_s;
  vec_t       tbl[8];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  int m_cnt, m_minr, m_maxr, m_minc, m_maxc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: output seen with nothing expected (t=%0t)", nm, $time);
  endtask

  function automatic bit ref_edge(input int lap, input int thr);
    int m;
    m = (lap >= 128) ? lap - 128 : 128 - lap;
    return m > thr;
  endfunction

  task automatic model_clear();
    m_cnt  = 0;
    m_minr = 1 << 30;
    m_maxr = -1;
    m_minc = 1 << 30;
    m_maxc = -1;
  endtask

  // Drive one sample for one clock; record what the DUT should produce for it.
  task automatic send(input int lap, input int row, input int col, input int thr, input bit e);
    exp_edge_t  xe;
    exp_stats_t xs;
    bus.lap_valid     = 1'b1;
    bus.lap_out       = 8'(lap);
    bus.center_row_s1 = 32'(row);
    bus.center_col_s1 = 32'(col);
    bus.threshold     = 8'(thr);
    if (row >= 0 && row < H && col >= 0 && col < W) begin
      xe.e   = e;
      xe.cyc = cyc + 1;
      q_e.push_back(xe);
      if (e) begin
        m_cnt++;
        if (row < m_minr) m_minr = row;
        if (row > m_maxr) m_maxr = row;
        if (col < m_minc) m_minc = col;
        if (col > m_maxc) m_maxc = col;
      end
      if (row == H - 1 && col == W - 2) begin
        xs.cnt   = 32'(m_cnt);
        xs.empty = (m_cnt == 0);
        xs.minr  = xs.empty ? 16'd0 : 16'(m_minr);
        xs.maxr  = xs.empty ? 16'd0 : 16'(m_maxr);
        xs.minc  = xs.empty ? 16'd0 : 16'(m_minc);
        xs.maxc  = xs.empty ? 16'd0 : 16'(m_maxc);
        xs.cyc   = cyc + 1;
        q_s.push_back(xs);
        model_clear();
      end
    end
    @(posedge clk);
    #1;
    bus.lap_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".edge_valid"},  32'(bus.edge_valid), 0);
    chk({tag, ".edge_bit"},    32'(bus.edge_bit), 0);
    chk({tag, ".stats_valid"}, 32'(bus.stats_valid), 0);
    chk({tag, ".edge_count"},  bus.edge_count, 0);
    chk({tag, ".min_row"},     32'(bus.bbox_min_row), 0);
    chk({tag, ".max_row"},     32'(bus.bbox_max_row), 0);
    chk({tag, ".min_col"},     32'(bus.bbox_min_col), 0);
    chk({tag, ".max_col"},     32'(bus.bbox_max_col), 0);
    chk({tag, ".bbox_empty"},  32'(bus.bbox_empty), 0);
    chk({tag, ".range_err"},   32'(bus.range_err), 0);
  endtask

  // Output monitor: every edge_valid / stats_valid must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.edge_valid) begin
        if (q_e.size() == 0) fail_now("unexpected_edge_valid");
        else begin
          mon_e = q_e.pop_front();
          chk("edge_bit", 32'(bus.edge_bit), 32'(mon_e.e));
          chk("edge_latency_cycle", 32'(cyc), 32'(mon_e.cyc));
        end
      end
      if (bus.stats_valid) begin
        if (q_s.size() == 0) fail_now("unexpected_stats_valid");
        else begin
          mon_s = q_s.pop_front();
          chk("stats_cycle",  32'(cyc), 32'(mon_s.cyc));
          chk("edge_count",   bus.edge_count, mon_s.cnt);
          chk("bbox_min_row", 32'(bus.bbox_min_row), 32'(mon_s.minr));
          chk("bbox_max_row", 32'(bus.bbox_max_row), 32'(mon_s.maxr));
          chk("bbox_min_col", 32'(bus.bbox_min_col), 32'(mon_s.minc));
          chk("bbox_max_col", 32'(bus.bbox_max_col), 32'(mon_s.maxc));
          chk("bbox_empty",   32'(bus.bbox_empty), 32'(mon_s.empty));
        end
      end
    end
  end

  initial begin
    tbl[0] = '{lap: 178, thr: 50,  e: 1'b0};
    tbl[1] = '{lap: 78,  thr: 50,  e: 1'b0};
    tbl[2] = '{lap: 178, thr: 49,  e: 1'b1};
    tbl[3] = '{lap: 78,  thr: 49,  e: 1'b1};
    tbl[4] = '{lap: 200, thr: 50,  e: 1'b1};
    tbl[5] = '{lap: 128, thr: 0,   e: 1'b0};
    tbl[6] = '{lap: 0,   thr: 127, e: 1'b1};
    tbl[7] = '{lap: 255, thr: 127, e: 1'b0};

    bus.lap_valid     = 1'b0;
    bus.lap_out       = 8'd128;
    bus.center_row_s1 = '0;
    bus.center_col_s1 = '0;
    bus.threshold     = '0;
    model_clear();

    #1;
    chk_all_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // One-sample frames at the frame-end position: threshold boundary table.
    for (int i = 0; i < 8; i++)
      send(tbl[i].lap, H - 1, W - 2, tbl[i].thr, tbl[i].e);

    // Single edge at (10,20); edge_bit must appear on the very next clock.
    for (int c = 18; c <= 22; c++) begin
      send((c == 20) ? 200 : 128, 10, c, 50, ref_edge((c == 20) ? 200 : 128, 50));
      if (c == 20) chk("single_edge_next_cycle", {30'd0, bus.edge_valid, bus.edge_bit}, 32'd3);
    end
    send(128, 50, 50, 50, 1'b0);
    send(128, H - 1, W - 2, 50, 1'b0);

    // Threshold drops to 0 mid-frame: remainder of the frame still uses 50.
    send(200, 99, 0, 50, ref_edge(200, 50));
    send(150, 99, 1, 50, ref_edge(150, 50));
    send(150, 100, 0, 0, ref_edge(150, 50));
    send(250, 100, 1, 0, ref_edge(250, 50));
    send(150, H - 1, W - 2, 0, ref_edge(150, 50));
    // Next frame picks up threshold 0; its frame end is followed back-to-back by a new frame.
    send(150, 0, 0, 0, ref_edge(150, 0));
    send(130, 5, 7, 0, ref_edge(130, 0));
    send(128, H - 1, W - 2, 0, ref_edge(128, 0));
    send(250, 0, 3, 0, ref_edge(250, 0));
    send(128, 1, 1, 0, ref_edge(128, 0));
    send(129, H - 1, W - 2, 0, ref_edge(129, 0));

    // Uniform full raster of interior samples: no edges, empty report.
    for (int r = 1; r < H; r++)
      for (int c = 1; c <= W - 2; c++)
        send(128, r, c, 0, 1'b0);

    // Out-of-range samples are dropped and set the sticky error flag.
    send(200, 2, 2, 10, ref_edge(200, 10));
    send(200, 2, W, 10, 1'b0);
    chk("range_err_set", 32'(bus.range_err), 1);
    send(200, H, 5, 10, 1'b0);
    send(128, H - 1, W - 2, 10, ref_edge(128, 10));
    send(0, H - 1, W - 2, 10, ref_edge(0, 10));
    repeat (2) @(posedge clk);
    #1;
    chk("range_err_sticky", 32'(bus.range_err), 1);

    // Asynchronous reset mid-frame clears everything without a clock edge.
    send(200, 3, 3, 10, ref_edge(200, 10));
    send(200, 3, 4, 10, ref_edge(200, 10));
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    model_clear();
    q_e.delete();
    q_s.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(200, 3, 5, 10, ref_edge(200, 10));
    repeat (5) @(posedge clk);
    #1;

    chk("edge_queue_drained",  32'(q_e.size()), 0);
    chk("stats_queue_drained", 32'(q_s.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
